// File: rtl/mario_pkg.sv
// mario_pkg
// Shared constants for the Mario game world: coordinate widths (also used by
// the VGA renderer), world limits, sprite size, sprite frame IDs and the
// ground/air motion state type.
// No ports; import with "import mario_pkg::*;".

package mario_pkg;

   // Coordinate and ID widths shared with the renderer
   localparam int X_W  = 11;
   localparam int Y_W  = 10;
   localparam int ID_W = 6;
   localparam int VY_W = 6;

   // World geometry
   localparam int START_X  = 64;
   localparam int GROUND_Y = 896;
   localparam int X_MAX    = 2015;
   localparam int SPRITE_W = 32;

   // Sprite frame IDs; left-facing frames sit ID_LEFT_OFS above right-facing ones
   localparam logic [ID_W-1:0] ID_STAND    = 6'd0;
   localparam logic [ID_W-1:0] ID_WALK1    = 6'd1;
   localparam logic [ID_W-1:0] ID_WALK2    = 6'd2;
   localparam logic [ID_W-1:0] ID_WALK3    = 6'd3;
   localparam logic [ID_W-1:0] ID_JUMP     = 6'd4;
   localparam logic [ID_W-1:0] ID_LEFT_OFS = 6'd8;

   typedef enum logic {
      ST_GROUND = 1'b0,
      ST_AIR    = 1'b1
   } move_state_t;

endpackage

// File: rtl/mario_world_tick_gen.sv
// tick_gen
// Free-running prescaler that produces a one-clock pulse every DIV clocks.
// Ports:
//   i_clk  - system clock
//   i_rst  - synchronous active-high reset, counter returns to 0
//   o_tick - high during the cycle where the counter holds DIV-1

module tick_gen #(
   parameter int DIV = 4
)(
   input  logic i_clk,
   input  logic i_rst,
   output logic o_tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_count;

   // Counter walks 0..DIV-1 and wraps; reset restarts the phase so the
   // first tick after reset lands DIV clocks later.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (r_count == LAST) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CW'(1);
      end
   end

   assign o_tick = (r_count == LAST);

endmodule

// File: rtl/mario_world.sv
// mario_world
// Physics and animation core: turns jump/left/right button levels into
// Mario's position, sprite frame and rising flag, advanced once per physics
// tick. All outputs come straight from registers and only change on the
// clock edge that ends a tick cycle.
// Ports:
//   i_clk, i_rst          - system clock, synchronous active-high reset
//   i_jump/i_left/i_right - button levels, sampled on tick cycles
//   o_mario_x             - sprite left edge, world coordinates
//   o_mario_y             - sprite top edge, screen coordinates
//   o_mario_id            - frame ID including facing offset
//   o_m_id                - base frame ID
//   o_rising              - high while vertical velocity is negative

module mario_world
   import mario_pkg::*;
#(
   parameter int TICK_DIV   = 1000000,
   parameter int WALK_SPEED = 2,
   parameter int JUMP_V     = 12,
   parameter int GRAVITY    = 1,
   parameter int MAX_FALL   = 12,
   parameter int ANIM_DIV   = 4
)(
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_jump,
   input  logic            i_left,
   input  logic            i_right,
   output logic [X_W-1:0]  o_mario_x,
   output logic [Y_W-1:0]  o_mario_y,
   output logic [ID_W-1:0] o_mario_id,
   output logic [ID_W-1:0] o_m_id,
   output logic            o_rising
);

   localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
   localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_DIV - 1);

   logic                   w_tick;
   move_state_t            r_state, w_nextState;
   logic [X_W-1:0]         r_x, w_x;
   logic [Y_W-1:0]         r_y, w_y;
   logic signed [VY_W-1:0] r_vy, w_vy;
   logic                   r_facingLeft, w_facingLeft;
   logic [ID_W-1:0]        r_frame, w_frame;
   logic [AW-1:0]          r_animCnt, w_animCnt;

   logic                   w_rightOnly, w_leftOnly, w_moving;
   logic [X_W:0]           w_xPlus;
   logic signed [X_W-1:0]  w_ySum;
   logic signed [VY_W:0]   w_vyPlus;
   logic signed [VY_W-1:0] w_vyFall;

   tick_gen #(
      .DIV(TICK_DIV)
   ) u_tickGen (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .o_tick(w_tick)
   );

   assign w_rightOnly = i_right & ~i_left;
   assign w_leftOnly  = i_left & ~i_right;
   assign w_moving    = i_right ^ i_left;

   // One bit of headroom so the right-edge clamp sees the overshoot
   assign w_xPlus = {1'b0, r_x} + (X_W+1)'(WALK_SPEED);

   // y + vy in 11-bit signed so both the ceiling (negative) and the
   // ground (>= GROUND_Y) crossings are visible
   assign w_ySum = $signed({{(X_W-Y_W){1'b0}}, r_y})
                 + $signed({{(X_W-VY_W){r_vy[VY_W-1]}}, r_vy});

   // Gravity applied in one extra bit, then limited to terminal velocity
   assign w_vyPlus = $signed({r_vy[VY_W-1], r_vy}) + $signed((VY_W+1)'(GRAVITY));
   assign w_vyFall = (w_vyPlus > $signed((VY_W+1)'(MAX_FALL))) ? VY_W'(MAX_FALL)
                                                               : w_vyPlus[VY_W-1:0];

   // State register: everything moves together on the edge ending a tick
   // cycle; reset wins at any time, including mid-jump.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_GROUND;
         r_x          <= X_W'(START_X);
         r_y          <= Y_W'(GROUND_Y);
         r_vy         <= '0;
         r_facingLeft <= 1'b0;
         r_frame      <= ID_STAND;
         r_animCnt    <= '0;
      end else begin
         r_state      <= w_nextState;
         r_x          <= w_x;
         r_y          <= w_y;
         r_vy         <= w_vy;
         r_facingLeft <= w_facingLeft;
         r_frame      <= w_frame;
         r_animCnt    <= w_animCnt;
      end
   end

   // Next-state logic: holds everything between ticks; on a tick it applies
   // walking, the ground/air state machine and the walk-cycle animation.
   always_comb begin
      w_nextState  = r_state;
      w_x          = r_x;
      w_y          = r_y;
      w_vy         = r_vy;
      w_facingLeft = r_facingLeft;
      w_frame      = r_frame;
      w_animCnt    = r_animCnt;

      if (w_tick) begin
         if (w_rightOnly) begin
            w_x          = (w_xPlus > (X_W+1)'(X_MAX)) ? X_W'(X_MAX) : w_xPlus[X_W-1:0];
            w_facingLeft = 1'b0;
         end else if (w_leftOnly) begin
            w_x          = (r_x < X_W'(WALK_SPEED)) ? '0 : r_x - X_W'(WALK_SPEED);
            w_facingLeft = 1'b1;
         end

         case (r_state)
            ST_GROUND: begin
               // Launch leaves y alone; the first move happens next tick
               if (i_jump) begin
                  w_vy        = VY_W'(-JUMP_V);
                  w_nextState = ST_AIR;
               end
            end
            ST_AIR: begin
               if (w_ySum[X_W-1]) begin
                  w_y  = '0;
                  w_vy = '0;
               end else if (w_ySum >= $signed(X_W'(GROUND_Y))) begin
                  w_y         = Y_W'(GROUND_Y);
                  w_vy        = '0;
                  w_nextState = ST_GROUND;
               end else begin
                  w_y  = w_ySum[Y_W-1:0];
                  w_vy = w_vyFall;
               end
            end
            default: w_nextState = ST_GROUND;
         endcase

         // Frame follows the post-tick state; entering a walk from stand or
         // from the air always starts at WALK1 with a fresh frame timer.
         if (w_nextState == ST_AIR) begin
            w_frame   = ID_JUMP;
            w_animCnt = '0;
         end else if (!w_moving) begin
            w_frame   = ID_STAND;
            w_animCnt = '0;
         end else if ((r_frame == ID_STAND) || (r_frame == ID_JUMP)) begin
            w_frame   = ID_WALK1;
            w_animCnt = '0;
         end else if (r_animCnt == ANIM_LAST) begin
            w_animCnt = '0;
            w_frame   = (r_frame == ID_WALK3) ? ID_WALK1 : r_frame + ID_W'(1);
         end else begin
            w_animCnt = r_animCnt + AW'(1);
         end
      end
   end

   assign o_mario_x  = r_x;
   assign o_mario_y  = r_y;
   assign o_m_id     = r_frame;
   assign o_mario_id = r_frame + (r_facingLeft ? ID_LEFT_OFS : '0);
   assign o_rising   = r_vy[VY_W-1];

endmodule

// File: tb/tb_mario_world.sv
// tb_mario_world
// Self-checking bench for mario_world with a fast physics tick. Fixed
// vectors carry hand-derived expectations; longer and randomized runs are
// compared against a tick-level behavioural model of the game rules.

module tb_mario_world;
   import mario_pkg::*;

   localparam int TICK_DIV = 4;
   localparam int WALK     = 2;
   localparam int JUMPV    = 12;
   localparam int GRAV     = 1;
   localparam int MAXF     = 12;
   localparam int ANIM     = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            btnJump = 1'b0;
   logic            btnLeft = 1'b0;
   logic            btnRight = 1'b0;
   logic [X_W-1:0]  marioX;
   logic [Y_W-1:0]  marioY;
   logic [ID_W-1:0] marioId;
   logic [ID_W-1:0] mId;
   logic            rising;

   int passCnt  = 0;
   int totalCnt = 0;

   // Behavioural model state
   int mX, mY, mVy, mWalk;
   bit mAir, mFaceLeft;

   typedef struct {
      bit j;
      bit l;
      bit r;
      int n;
      int ex;
      int ey;
      int emid;
      int eid;
      bit erise;
   } vec_t;

   vec_t vecs[11];

   mario_world #(
      .TICK_DIV  (TICK_DIV),
      .WALK_SPEED(WALK),
      .JUMP_V    (JUMPV),
      .GRAVITY   (GRAV),
      .MAX_FALL  (MAXF),
      .ANIM_DIV  (ANIM)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_jump    (btnJump),
      .i_left    (btnLeft),
      .i_right   (btnRight),
      .o_mario_x (marioX),
      .o_mario_y (marioY),
      .o_mario_id(marioId),
      .o_m_id    (mId),
      .o_rising  (rising)
   );

   // 10 ns system clock
   always #5 clk = ~clk;

   // Single comparison: bumps the counters and reports a miss
   function automatic void checkVal(string name, int act, int exp);
      totalCnt++;
      if (act == exp) passCnt++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
   endfunction

   task automatic checkOutput(string tag, int ex, int ey, int emid, int eid, bit erise);
      checkVal({tag, ".x"},      int'(marioX),  ex);
      checkVal({tag, ".y"},      int'(marioY),  ey);
      checkVal({tag, ".m_id"},   int'(mId),     emid);
      checkVal({tag, ".id"},     int'(marioId), eid);
      checkVal({tag, ".rising"}, int'(rising),  int'(erise));
   endtask

   // Game rules at tick granularity, written from position/velocity arithmetic
   function automatic void modelReset();
      mX = START_X; mY = GROUND_Y; mVy = 0; mWalk = 0;
      mAir = 1'b0; mFaceLeft = 1'b0;
   endfunction

   function automatic void modelTick(bit j, bit l, bit r);
      int ny;
      if (r && !l) begin
         mX = (mX + WALK > X_MAX) ? X_MAX : mX + WALK;
         mFaceLeft = 1'b0;
      end else if (l && !r) begin
         mX = (mX - WALK < 0) ? 0 : mX - WALK;
         mFaceLeft = 1'b1;
      end
      if (!mAir) begin
         if (j) begin
            mVy = -JUMPV;
            mAir = 1'b1;
         end
      end else begin
         ny  = mY + mVy;
         mVy = (mVy + GRAV > MAXF) ? MAXF : mVy + GRAV;
         if (ny < 0) begin
            mY = 0; mVy = 0;
         end else if (ny >= GROUND_Y) begin
            mY = GROUND_Y; mVy = 0; mAir = 1'b0;
         end else begin
            mY = ny;
         end
      end
      // Length of the current uninterrupted walk on the ground
      if (mAir || (l == r)) mWalk = 0;
      else mWalk++;
   endfunction

   function automatic int expMid();
      if (mAir) return 4;
      if (mWalk == 0) return 0;
      return 1 + ((mWalk - 1) / ANIM) % 3;
   endfunction

   task automatic checkModel(string tag);
      int em;
      em = expMid();
      checkOutput(tag, mX, mY, em, em + (mFaceLeft ? 8 : 0), mVy < 0);
   endtask

   // Drive, then advance one full tick period and sample 1 ns after the
   // updating edge
   task automatic stepTick();
      repeat (TICK_DIV) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(bit j, bit l, bit r, int n);
      btnJump = j; btnLeft = l; btnRight = r;
      repeat (n) stepTick();
   endtask

   task automatic modelStep(bit j, bit l, bit r, string tag);
      btnJump = j; btnLeft = l; btnRight = r;
      modelTick(j, l, r);
      stepTick();
      checkModel(tag);
   endtask

   task automatic doReset();
      btnJump = 0; btnLeft = 0; btnRight = 0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      //          j  l  r   n    x    y   mid id rise
      vecs[0]  = '{0, 0, 0, 10,  64, 896, 0,  0,  0};
      vecs[1]  = '{0, 0, 1, 1,   66, 896, 1,  1,  0};
      vecs[2]  = '{0, 0, 1, 3,   72, 896, 1,  1,  0};
      vecs[3]  = '{0, 0, 1, 1,   74, 896, 2,  2,  0};
      vecs[4]  = '{0, 1, 0, 1,   72, 896, 2,  10, 0};
      vecs[5]  = '{0, 1, 1, 1,   72, 896, 0,  8,  0};
      vecs[6]  = '{1, 0, 0, 1,   72, 896, 4,  12, 1};
      vecs[7]  = '{0, 0, 0, 1,   72, 884, 4,  12, 1};
      vecs[8]  = '{0, 0, 1, 11,  94, 818, 4,  4,  0};
      vecs[9]  = '{0, 0, 0, 13,  94, 896, 0,  0,  0};
      vecs[10] = '{0, 1, 0, 50,  0,  896, 1,  9,  0};

      doReset();
      checkOutput("reset", 64, 896, 0, 0, 0);

      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].j, vecs[i].l, vecs[i].r, vecs[i].n);
         checkOutput($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey,
                     vecs[i].emid, vecs[i].eid, vecs[i].erise);
      end

      // Outputs hold between ticks and move on the edge ending the tick cycle
      doReset();
      btnRight = 1'b1;
      for (int c = 1; c <= TICK_DIV; c++) begin
         @(posedge clk);
         #1;
         checkVal($sformatf("latency.clk%0d", c), int'(marioX), (c < TICK_DIV) ? 64 : 66);
      end

      // Reset in the middle of a jump, away from a tick boundary
      doReset();
      applyStimulus(1, 0, 0, 1);
      applyStimulus(0, 0, 0, 12);
      checkVal("midjump.y", int'(marioY), 818);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("midrst", 64, 896, 0, 0, 0);
      applyStimulus(0, 0, 0, 1);
      checkOutput("postrst", 64, 896, 0, 0, 0);

      // Right and jump held: x saturates at X_MAX, 26-tick jump cycles
      doReset();
      modelReset();
      for (int t = 1; t <= 990; t++) begin
         modelStep(1, 0, 1, $sformatf("hold%0d", t));
         if (t == 26) checkOutput("land26", 64 + 52, 896, 1, 1, 0);
         if (t == 27) checkOutput("relaunch27", 64 + 54, 896, 4, 4, 1);
         if (t == 976 || t == 990) checkVal($sformatf("xmax%0d", t), int'(marioX), 2015);
      end

      // Randomized buttons against the model
      doReset();
      modelReset();
      for (int t = 0; t < 400; t++) begin
         modelStep($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 2) != 0, $sformatf("rand%0d", t));
      end

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
